calc_issue_ctrl: RTL and testbench

CALC_ISSUE_CTRL -- requirements
Module: calc_issue_ctrl

---
 rtl/calc_pkg.sv | 32 +++
 rtl/calc_sync_fifo.sv | 58 +++++
 rtl/calc_issue_ctrl.sv | 196 +++++++++++++++++++
 tb/tb_calc_issue_ctrl.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// Shared types for the calculator issue controller: opcodes, command and
// result records, and the default calculator latency.
package calc_pkg;

    typedef enum logic [1:0] {
        OP_SUM = 2'b00,
        OP_SUB = 2'b01,
        OP_MUL = 2'b10,
        OP_DIV = 2'b11
    } calc_op_e;

    typedef struct packed {
        calc_op_e   func;
        logic [7:0] a;
        logic [7:0] b;
    } calc_cmd_t;

    typedef struct packed {
        logic [15:0] data;
        logic        div0;
    } calc_res_t;

    localparam int unsigned LATENCY_BLOCK_DEF = 2;
    localparam int unsigned CMD_W             = $bits(calc_cmd_t);
    localparam int unsigned RES_W             = $bits(calc_res_t);

    // A divide whose divisor is zero; the calculator saturates these.
    function automatic logic is_div0(input calc_op_e func, input logic [7:0] b);
        return (func == OP_DIV) && (b == 8'h00);
    endfunction

endpackage

// File: rtl/calc_sync_fifo.sv
// Single-clock FIFO with full/empty/count; a pop frees the slot for a
// same-cycle push, so a full FIFO accepts push+pop together.
module calc_sync_fifo #(
    parameter  int unsigned WIDTH = 8,
    parameter  int unsigned DEPTH = 4,
    localparam int unsigned AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_full,
    output logic             o_empty,
    output logic [AW:0]      o_count
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [AW:0]      r_count;
    logic             w_push;
    logic             w_pop;

    assign o_empty = (r_count == '0);
    assign o_full  = (r_count == (AW+1)'(DEPTH));
    assign o_count = r_count;
    assign o_rdata = r_mem[r_rptr];
    assign w_pop   = i_pop && !o_empty;
    assign w_push  = i_push && (!o_full || w_pop);

    // Storage write, pointer advance and occupancy tracking.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wptr] <= i_wdata;
                r_wptr        <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/calc_issue_ctrl.sv
// Credit-based issue controller: queues commands, drives the fixed-latency
// calculator one operation per cycle, and captures results in order.
module calc_issue_ctrl
    import calc_pkg::*;
#(
    parameter int unsigned LATENCY_BLOCK = LATENCY_BLOCK_DEF,
    parameter int unsigned CMD_DEPTH     = 4,
    parameter int unsigned RES_DEPTH     = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_func,
    input  logic [7:0]  cmd_a,
    input  logic [7:0]  cmd_b,
    output logic [1:0]  function_in,
    output logic [7:0]  dat_a_in,
    output logic [7:0]  dat_b_in,
    input  logic [15:0] out,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [15:0] res_data,
    output logic        res_div0,
    output logic [15:0] sat_cnt
);

    localparam int unsigned CAW = $clog2(CMD_DEPTH);
    localparam int unsigned RAW = $clog2(RES_DEPTH);

    // command side
    logic             r_rdy;
    calc_cmd_t        w_cmd_in;
    calc_cmd_t        w_cmd_head;
    logic [CMD_W-1:0] w_cmd_rdata;
    logic             w_cmd_push;
    logic             w_cmd_full;
    logic             w_cmd_empty;
    logic [CAW:0]     w_cmd_count;

    // result side
    calc_res_t        w_res_in;
    calc_res_t        w_res_head;
    logic [RES_W-1:0] w_res_rdata;
    logic             w_res_pop;
    logic             w_res_full;
    logic             w_res_empty;
    logic [RAW:0]     w_res_count;

    // issue / drive / latency pipe
    logic [4:0]               r_inflight;
    logic [5:0]               w_used;
    logic [5:0]               w_limit;
    logic                     w_issue;
    calc_op_e                 r_func;
    logic [7:0]               r_a;
    logic [7:0]               r_b;
    logic                     r_drv_v;
    logic                     w_drv_z;
    logic [LATENCY_BLOCK-1:0] r_pipe_v;
    logic [LATENCY_BLOCK-1:0] r_pipe_z;
    logic                     w_cap;
    logic                     w_cap_z;
    logic [15:0]              r_sat;
    logic                     w_unused;

    assign w_cmd_in   = '{func: calc_op_e'(cmd_func), a: cmd_a, b: cmd_b};
    assign w_cmd_head = calc_cmd_t'(w_cmd_rdata);
    assign w_cmd_push = cmd_valid && cmd_ready;
    assign cmd_ready  = r_rdy && !w_cmd_full;

    calc_sync_fifo #(
        .WIDTH (CMD_W),
        .DEPTH (CMD_DEPTH)
    ) u_cmd_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_cmd_push),
        .i_wdata (w_cmd_in),
        .i_pop   (w_issue),
        .o_rdata (w_cmd_rdata),
        .o_full  (w_cmd_full),
        .o_empty (w_cmd_empty),
        .o_count (w_cmd_count)
    );

    // A result popped this cycle releases its slot before any capture that
    // the current issue could cause, so it counts as a credit already; this
    // keeps a continuous stream bubble-free while never overfilling.
    assign w_res_pop = res_ready && !w_res_empty;
    assign w_used    = 6'(w_res_count) + 6'(r_inflight);
    assign w_limit   = 6'(RES_DEPTH) + 6'(w_res_pop);
    assign w_issue   = !w_cmd_empty && (w_used < w_limit);

    assign w_drv_z = r_drv_v && is_div0(r_func, r_b);
    assign w_cap   = r_pipe_v[LATENCY_BLOCK-1];
    assign w_cap_z = r_pipe_z[LATENCY_BLOCK-1];

    assign w_res_in   = '{data: out, div0: w_cap_z};
    assign w_res_head = calc_res_t'(w_res_rdata);

    calc_sync_fifo #(
        .WIDTH (RES_W),
        .DEPTH (RES_DEPTH)
    ) u_res_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_cap),
        .i_wdata (w_res_in),
        .i_pop   (w_res_pop),
        .o_rdata (w_res_rdata),
        .o_full  (w_res_full),
        .o_empty (w_res_empty),
        .o_count (w_res_count)
    );

    assign res_valid   = !w_res_empty;
    assign res_data    = res_valid ? w_res_head.data : '0;
    assign res_div0    = res_valid && w_res_head.div0;
    assign sat_cnt     = r_sat;
    assign function_in = r_func;
    assign dat_a_in    = r_a;
    assign dat_b_in    = r_b;

    assign w_unused = ^{w_cmd_count, w_res_full};

    // cmd_ready opens on the first clock edge after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdy <= 1'b0;
        end else begin
            r_rdy <= 1'b1;
        end
    end

    // Register the FIFO head onto the calculator for exactly one cycle per issue.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_func  <= OP_SUM;
            r_a     <= '0;
            r_b     <= '0;
            r_drv_v <= 1'b0;
        end else if (w_issue) begin
            r_func  <= w_cmd_head.func;
            r_a     <= w_cmd_head.a;
            r_b     <= w_cmd_head.b;
            r_drv_v <= 1'b1;
        end else begin
            r_func  <= OP_SUM;
            r_a     <= '0;
            r_b     <= '0;
            r_drv_v <= 1'b0;
        end
    end

    // Track each drive cycle through the calculator latency with its div0 tag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pipe_v <= '0;
            r_pipe_z <= '0;
        end else begin
            r_pipe_v[0] <= r_drv_v;
            r_pipe_z[0] <= w_drv_z;
            for (int unsigned i = 1; i < LATENCY_BLOCK; i++) begin
                r_pipe_v[i] <= r_pipe_v[i-1];
                r_pipe_z[i] <= r_pipe_z[i-1];
            end
        end
    end

    // Operations issued but not yet captured into the result FIFO.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_inflight <= '0;
        end else begin
            unique case ({w_issue, w_cap})
                2'b10:   r_inflight <= r_inflight + 1'b1;
                2'b01:   r_inflight <= r_inflight - 1'b1;
                default: r_inflight <= r_inflight;
            endcase
        end
    end

    // Saturating count of captured divide-by-zero results.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sat <= '0;
        end else if (w_cap && w_cap_z && (r_sat != 16'hFFFF)) begin
            r_sat <= r_sat + 1'b1;
        end
    end

    a_no_res_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(w_cap && w_res_full && !w_res_pop));

endmodule

// File: tb/tb_calc_issue_ctrl.sv
// Self-checking bench: stub calculator, queue-based behavioural model,
// directed scenarios with literal expectations, then randomized traffic.
module tb_calc_issue_ctrl;

    localparam int L  = 2;
    localparam int CD = 4;
    localparam int RD = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_func;
    logic [7:0]  cmd_a;
    logic [7:0]  cmd_b;
    logic [1:0]  function_in;
    logic [7:0]  dat_a_in;
    logic [7:0]  dat_b_in;
    logic [15:0] out;
    logic        res_valid;
    logic        res_ready;
    logic [15:0] res_data;
    logic        res_div0;
    logic [15:0] sat_cnt;

    always #5 clk = ~clk;

    calc_issue_ctrl #(
        .LATENCY_BLOCK (L),
        .CMD_DEPTH     (CD),
        .RES_DEPTH     (RD)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_func    (cmd_func),
        .cmd_a       (cmd_a),
        .cmd_b       (cmd_b),
        .function_in (function_in),
        .dat_a_in    (dat_a_in),
        .dat_b_in    (dat_b_in),
        .out         (out),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_data    (res_data),
        .res_div0    (res_div0),
        .sat_cnt     (sat_cnt)
    );

    // Calculator arithmetic: signed 8-bit operands, 16-bit result,
    // divide by zero saturates toward the sign of the dividend.
    function automatic logic [15:0] calc(input logic [1:0] f, input logic [7:0] a, input logic [7:0] b);
        int ia, ib, r;
        ia = int'($signed(a));
        ib = int'($signed(b));
        case (f)
            2'd0:    r = ia + ib;
            2'd1:    r = ia - ib;
            2'd2:    r = ia * ib;
            default: r = (ib == 0) ? ((ia < 0) ? -32768 : 32767) : ia / ib;
        endcase
        return 16'(r);
    endfunction

    // Stub calculator: result appears L cycles after the operands are driven.
    logic [15:0] stub [L];
    always @(posedge clk) begin
        stub[0] <= calc(function_in, dat_a_in, dat_b_in);
        for (int i = 1; i < L; i++) stub[i] <= stub[i-1];
    end
    assign out = stub[L-1];

    typedef struct {
        logic [1:0] f;
        logic [7:0] a;
        logic [7:0] b;
    } tcmd_t;

    tcmd_t       cmdq [$];
    tcmd_t       fly  [$];
    int          age  [$];
    logic [15:0] rq_d [$];
    logic        rq_z [$];
    int          msat;
    bit          mrdy;
    bit          exp_rdy;
    int          total = 0;
    int          bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        cmdq.delete(); fly.delete(); age.delete(); rq_d.delete(); rq_z.delete();
        msat = 0;
        mrdy = 0;
    endtask

    // Compare every DUT output against the model's view of the current cycle.
    task automatic compare();
        tcmd_t d;
        d.f = 2'd0; d.a = 8'd0; d.b = 8'd0;
        exp_rdy = mrdy && (cmdq.size() < CD);
        if (fly.size() > 0 && age[fly.size()-1] == 0) d = fly[fly.size()-1];
        chk("cmd_ready",   {31'd0, cmd_ready}, {31'd0, exp_rdy});
        chk("function_in", {30'd0, function_in}, {30'd0, d.f});
        chk("dat_a_in",    {24'd0, dat_a_in}, {24'd0, d.a});
        chk("dat_b_in",    {24'd0, dat_b_in}, {24'd0, d.b});
        chk("res_valid",   {31'd0, res_valid}, (rq_d.size() > 0) ? 32'd1 : 32'd0);
        chk("res_data",    {16'd0, res_data}, (rq_d.size() > 0) ? {16'd0, rq_d[0]} : 32'd0);
        chk("res_div0",    {31'd0, res_div0}, (rq_d.size() > 0) ? {31'd0, rq_z[0]} : 32'd0);
        chk("sat_cnt",     {16'd0, sat_cnt}, msat);
    endtask

    // Advance the model across one rising edge using the inputs just driven.
    task automatic model_edge();
        bit    pop, iss, acc, z;
        tcmd_t c;
        pop = res_ready && (rq_d.size() > 0);
        iss = (cmdq.size() > 0) && ((rq_d.size() + fly.size()) < (RD + int'(pop)));
        acc = cmd_valid && exp_rdy;
        if (pop) begin
            void'(rq_d.pop_front());
            void'(rq_z.pop_front());
        end
        if (fly.size() > 0 && age[0] == L) begin
            c = fly.pop_front();
            void'(age.pop_front());
            z = (c.f == 2'd3) && (c.b == 8'd0);
            rq_d.push_back(calc(c.f, c.a, c.b));
            rq_z.push_back(z);
            if (z && msat < 65535) msat++;
        end
        foreach (age[i]) age[i]++;
        if (iss) begin
            fly.push_back(cmdq.pop_front());
            age.push_back(0);
        end
        if (acc) begin
            c.f = cmd_func; c.a = cmd_a; c.b = cmd_b;
            cmdq.push_back(c);
        end
        mrdy = 1;
    endtask

    task automatic step(input bit v, input logic [1:0] f, input logic [7:0] a,
                        input logic [7:0] b, input bit rr);
        @(negedge clk);
        compare();
        cmd_valid = v;
        cmd_func  = f;
        cmd_a     = a;
        cmd_b     = b;
        res_ready = rr;
        if (rst_n) model_edge();
    endtask

    task automatic do_reset(input int n);
        @(negedge clk);
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        res_ready = 1'b0;
        model_reset();
        #1;
        compare();
        chk("rst_res_valid", {31'd0, res_valid}, 32'd0);
        chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
        repeat (n) step(0, 2'd0, 8'd0, 8'd0, 0);
        @(negedge clk);
        compare();
        rst_n = 1'b1;
        model_edge();
    endtask

    logic [15:0] got_d [$];
    logic        got_z [$];
    int          first_s;
    int          acc_n;
    int          vcnt;

    initial begin
        rst_n = 1'b1; cmd_valid = 1'b0; cmd_func = 2'd0; cmd_a = 8'd0; cmd_b = 8'd0;
        res_ready = 1'b0;
        model_reset();

        // One multiply 3 * -4: drive two cycles after the command, result L later.
        do_reset(2);
        first_s = -1;
        step(1, 2'd2, 8'd3, 8'hFC, 1);
        for (int s = 1; s <= 10; s++) begin
            step(0, 2'd0, 8'd0, 8'd0, 1);
            if (s == 2) begin
                chk("drv_func", {30'd0, function_in}, 32'd2);
                chk("drv_a",    {24'd0, dat_a_in}, 32'd3);
                chk("drv_b",    {24'd0, dat_b_in}, 32'hFC);
            end
            if (res_valid && first_s < 0) begin
                first_s = s;
                chk("mul_data", {16'd0, res_data}, 32'hFFF4);
                chk("mul_div0", {31'd0, res_div0}, 32'd0);
            end
        end
        chk("mul_latency", first_s, L + 3);

        // Two divides by zero saturate positive then negative, in order.
        got_d.delete(); got_z.delete();
        step(1, 2'd3, 8'd5, 8'd0, 1);
        step(1, 2'd3, 8'hFB, 8'd0, 1);
        for (int s = 0; s < 15; s++) begin
            step(0, 2'd0, 8'd0, 8'd0, 1);
            if (res_valid) begin
                got_d.push_back(res_data);
                got_z.push_back(res_div0);
            end
        end
        chk("div0_count", got_d.size(), 2);
        if (got_d.size() == 2) begin
            chk("div0_pos", {16'd0, got_d[0]}, 32'h7FFF);
            chk("div0_neg", {16'd0, got_d[1]}, 32'h8000);
            chk("div0_tag0", {31'd0, got_z[0]}, 32'd1);
            chk("div0_tag1", {31'd0, got_z[1]}, 32'd1);
        end
        chk("sat_cnt_2", {16'd0, sat_cnt}, 32'd2);

        // Backpressure: eight sums with res_ready low fill both FIFOs.
        do_reset(1);
        acc_n = 0;
        for (int s = 0; s < 30; s++) begin
            step(acc_n < 8, 2'd0, 8'(acc_n), 8'd1, 0);
            if (cmd_valid && cmd_ready) acc_n++;
        end
        chk("bp_accepts", acc_n, 8);
        chk("bp_cmd_ready", {31'd0, cmd_ready}, 32'd0);
        chk("bp_res_valid", {31'd0, res_valid}, 32'd1);
        got_d.delete();
        for (int s = 0; s < 40; s++) begin
            step(0, 2'd0, 8'd0, 8'd0, 1);
            if (res_valid) got_d.push_back(res_data);
        end
        chk("bp_drained", got_d.size(), 8);
        foreach (got_d[i]) chk("bp_order", {16'd0, got_d[i]}, i + 1);

        // Continuous stream: one result per cycle once the pipe is full.
        do_reset(1);
        vcnt = 0;
        for (int s = 0; s < 40; s++) begin
            step(1, 2'($urandom), 8'($urandom), 8'($urandom_range(1, 255)), 1);
            if (s >= 20 && res_valid) vcnt++;
        end
        chk("stream_rate", vcnt, 20);
        repeat (12) step(0, 2'd0, 8'd0, 8'd0, 1);

        // Reset with work queued and in flight: nothing reappears afterwards.
        do_reset(1);
        repeat (5) step(1, 2'($urandom), 8'($urandom), 8'($urandom), 0);
        do_reset(3);
        vcnt = 0;
        for (int s = 0; s < 10; s++) begin
            step(0, 2'd0, 8'd0, 8'd0, 1);
            if (res_valid) vcnt++;
        end
        chk("post_rst_quiet", vcnt, 0);

        // Randomized traffic with a reset in the middle.
        for (int s = 0; s < 800; s++) begin
            if (s == 400) do_reset(2);
            step($urandom_range(0, 3) != 0, 2'($urandom),
                 8'($urandom),
                 ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom),
                 $urandom_range(0, 2) != 0);
        end
        repeat (20) step(0, 2'd0, 8'd0, 8'd0, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
